pwencoder: RTL and testbench

- Downstream neighbour of the password incrementer.
- Takes a candidate (20 ASCII chars packed in 160 bits, plus length) on a trigger pulse and builds the single 512-bit MD4 message block that the NT hash core consumes.
- The block holds the password as UTF-16LE, followed by MD4 padding and the 64-bit bit-length field.
- Works serially, one character per cycle.
- Output side: valid/ready handshake to the MD4 stage.

---
 rtl/pwenc_pkg.sv | 19 +
 rtl/pwenc_bytewrite.sv | 17 +
 rtl/pwencoder.sv | 136 +++++++++++++
 tb/tb_pwencoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pwenc_pkg.sv
// Shared types and constants for the password-to-MD4-block encoder.
package pwenc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        CLEAR,
        FILL,
        PAD,
        DONE
    } pwenc_state_t;

    localparam int unsigned MD4_BLOCK_W    = 512;
    localparam logic [7:0]  MD4_PAD_BYTE   = 8'h80;
    localparam int unsigned LEN_FIELD_BYTE = 56;
    localparam logic [7:0]  CHAR_MIN       = 8'h20;
    localparam logic [7:0]  CHAR_MAX       = 8'h7E;

endpackage

// File: rtl/pwenc_bytewrite.sv
// One-hot byte write-enable decode into the 512-bit MD4 block.
module pwenc_bytewrite
    import pwenc_pkg::*;
#(
    parameter int unsigned NBYTES = MD4_BLOCK_W / 8
) (
    input  logic [5:0]        idx,
    input  logic              en,
    output logic [NBYTES-1:0] be
);

    always_comb begin
        be = '0;
        if (en) be[idx] = 1'b1;
    end

endmodule

// File: rtl/pwencoder.sv
// Serial UTF-16LE + MD4-padding block builder for the NT hash core.
// Define PWENC_CHARCHECK_EN to reject candidates with non-printable characters.
module pwencoder
    import pwenc_pkg::*;
#(
    parameter int unsigned MAX_CHARS = 20,
    parameter int unsigned CHAR_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MAX_CHARS*CHAR_W-1:0] in_password,
    input  logic [4:0]                  in_length,
    input  logic                        trigger,
    output logic                        in_ready,
    output logic [MD4_BLOCK_W-1:0]      out_block,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        err
);

    pwenc_state_t state, state_n;

    logic [MAX_CHARS*CHAR_W-1:0] pw_q;
    logic [4:0]                  len_q;
    logic [4:0]                  idx_q;
    logic [CHAR_W-1:0]           cur_char;
    logic                        too_long;
    logic                        last_char;
    logic                        char_bad;
    logic [5:0]                  wr_idx;
    logic                        wr_en;
    logic [7:0]                  wr_byte;
    logic [MD4_BLOCK_W/8-1:0]    be;
    logic [15:0]                 bit_len;

    always_comb begin
        cur_char  = pw_q[idx_q*CHAR_W +: CHAR_W];
        too_long  = (32'(len_q) > MAX_CHARS);
        last_char = (idx_q == len_q - 5'd1);
        bit_len   = 16'({len_q, 4'b0000});
`ifdef PWENC_CHARCHECK_EN
        char_bad  = (cur_char < CHAR_MIN) || (cur_char > CHAR_MAX);
`else
        char_bad  = 1'b0;
`endif
    end

    // A single decoder serves both the character write and the pad-byte write.
    always_comb begin
        wr_idx  = {idx_q, 1'b0};
        wr_byte = 8'(cur_char);
        wr_en   = 1'b0;
        if (state == FILL) begin
            wr_en = !char_bad;
        end else if (state == PAD) begin
            wr_idx  = {len_q, 1'b0};
            wr_byte = MD4_PAD_BYTE;
            wr_en   = 1'b1;
        end
    end

    pwenc_bytewrite #(.NBYTES(MD4_BLOCK_W / 8)) u_bytewrite (
        .idx (wr_idx),
        .en  (wr_en),
        .be  (be)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (trigger) state_n = CHECK;
            CHECK:   state_n = too_long ? IDLE : CLEAR;
            CLEAR:   state_n = (len_q != 5'd0) ? FILL : PAD;
            FILL: begin
                if (char_bad)       state_n = IDLE;
                else if (last_char) state_n = PAD;
            end
            PAD:     state_n = DONE;
            DONE:    if (out_valid && out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pw_q      <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            out_block <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        pw_q  <= in_password;
                        len_q <= in_length;
                        idx_q <= '0;
                    end
                end
                CHECK: if (too_long) err <= 1'b1;
                CLEAR: out_block <= '0;
                FILL: begin
                    if (char_bad) begin
                        err       <= 1'b1;
                        out_block <= '0;
                    end else begin
                        // Character lands on the even byte, its UTF-16LE high byte is zero.
                        for (int unsigned k = 0; k < MD4_BLOCK_W / 8; k++)
                            if (be[k]) out_block[8*k +: 8] <= wr_byte;
                        for (int unsigned k = 1; k < MD4_BLOCK_W / 8; k++)
                            if (be[k-1]) out_block[8*k +: 8] <= '0;
                        idx_q <= idx_q + 5'd1;
                    end
                end
                PAD: begin
                    for (int unsigned k = 0; k < MD4_BLOCK_W / 8; k++)
                        if (be[k]) out_block[8*k +: 8] <= wr_byte;
                    out_block[8*LEN_FIELD_BYTE +: 64] <= {48'h0, bit_len};
                    out_valid <= 1'b1;
                end
                DONE: if (out_valid && out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pwencoder.sv
// Directed bench for pwencoder with a queue scoreboard of expected blocks.
module tb_pwencoder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [159:0] in_password = '0;
    logic [4:0]   in_length = '0;
    logic         trigger = 1'b0;
    logic         in_ready;
    logic [511:0] out_block;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         err;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    logic [511:0] exp_q[$];

    always #5 clk = ~clk;

    pwencoder #(.MAX_CHARS(20), .CHAR_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_password (in_password),
        .in_length   (in_length),
        .trigger     (trigger),
        .in_ready    (in_ready),
        .out_block   (out_block),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [511:0] model(input logic [159:0] pw, input logic [4:0] len);
        logic [511:0] b;
        logic [15:0]  bits;
        b = '0;
        for (int i = 0; i < int'(len); i++) b[16*i +: 8] = pw[8*i +: 8];
        b[16*int'(len) +: 8] = 8'h80;
        bits = 16'(len) * 16'd16;
        b[448 +: 64] = {48'h0, bits};
        return b;
    endfunction

    function automatic logic [159:0] rand_pw();
        logic [159:0] p;
        for (int i = 0; i < 20; i++) p[8*i +: 8] = 8'($urandom_range(32, 126));
        return p;
    endfunction

    task automatic pulse_trigger(input logic [159:0] pw, input logic [4:0] len);
        @(negedge clk);
        in_password = pw;
        in_length   = len;
        trigger     = 1'b1;
        @(posedge clk);
        #1;
        trigger     = 1'b0;
        in_password = {5{$urandom()}};
        in_length   = 5'($urandom_range(0, 31));
    endtask

    // Returns at the negedge where out_valid is first seen; lat counts edges after the trigger edge.
    task automatic run_block(input logic [159:0] pw, input logic [4:0] len, input string tag,
                             output logic [511:0] blk);
        int lat;
        exp_q.push_back(model(pw, len));
        pulse_trigger(pw, len);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = c - 1;
                break;
            end
        end
        chk({tag, "_latency"}, 512'(lat), 512'(int'(len) + 3));
        chk({tag, "_sb_nonempty"}, 512'(exp_q.size() > 0), 512'(1));
        blk = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk({tag, "_block"}, out_block, blk);
    endtask

    task automatic watch_quiet(input int cycles, output int errs, output int valids);
        errs = 0;
        valids = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (err === 1'b1) errs++;
            if (out_valid !== 1'b0) valids++;
        end
    endtask

    initial begin
        logic [511:0] blk;
        logic [159:0] pw;
        logic [4:0]   len;
        int           errs, valids;

        #12;
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_err", 512'(err), 512'(0));
        chk("rst_block", out_block, '0);
        @(negedge clk);
        rst = 1'b0;

        // "abc"
        run_block(160'h636261, 5'd3, "abc", blk);
        chk("abc_X0", 512'(out_block[31:0]), 512'(32'h00620061));
        chk("abc_X1", 512'(out_block[63:32]), 512'(32'h00800063));
        chk("abc_X2_13", 512'(out_block[447:64]), '0);
        chk("abc_X14", 512'(out_block[479:448]), 512'(32'h00000030));
        chk("abc_X15", 512'(out_block[511:480]), '0);
        chk("abc_busy", 512'(in_ready), 512'(0));
        @(negedge clk);
        chk("abc_valid_drop", 512'(out_valid), 512'(0));
        chk("abc_in_ready", 512'(in_ready), 512'(1));

        // empty password
        run_block(160'h0, 5'd0, "len0", blk);
        chk("len0_X0", 512'(out_block[31:0]), 512'(32'h00000080));
        chk("len0_rest", 512'(out_block[511:32]), '0);
        @(negedge clk);

        // maximum length, top printable char
        pw = {20{8'h7E}};
        run_block(pw, 5'd20, "len20", blk);
        chk("len20_b40", 512'(out_block[327:320]), 512'(8'h80));
        chk("len20_b1", 512'(out_block[15:8]), 512'(8'h00));
        chk("len20_b38", 512'(out_block[311:304]), 512'(8'h7E));
        chk("len20_X14", 512'(out_block[479:448]), 512'(32'h00000140));
        @(negedge clk);

        // over-length rejection
        pulse_trigger(rand_pw(), 5'd21);
        watch_quiet(12, errs, valids);
        chk("len21_err_pulses", 512'(errs), 512'(1));
        chk("len21_no_valid", 512'(valids), 512'(0));
        chk("len21_in_ready", 512'(in_ready), 512'(1));

        // backpressure with an ignored trigger inside the hold window
        out_ready = 1'b0;
        pw = rand_pw();
        run_block(pw, 5'd5, "bp", blk);
        for (int i = 0; i < 5; i++) begin
            trigger = (i == 1);
            if (i == 1) begin
                in_password = rand_pw();
                in_length   = 5'd2;
            end
            @(negedge clk);
            chk("bp_valid_held", 512'(out_valid), 512'(1));
            chk("bp_block_stable", out_block, blk);
            chk("bp_in_ready", 512'(in_ready), 512'(0));
        end
        trigger = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop", 512'(out_valid), 512'(0));
        watch_quiet(10, errs, valids);
        chk("bp_trigger_ignored", 512'(valids), 512'(0));
        chk("bp_block_kept", out_block, blk);

        // random lengths, inputs scrambled after the trigger
        for (int t = 0; t < 4; t++) begin
            len = 5'($urandom_range(1, 20));
            run_block(rand_pw(), len, "rand", blk);
            @(negedge clk);
        end

        // asynchronous reset in the middle of FILL
        pw = rand_pw();
        pulse_trigger(pw, 5'd10);
        repeat (6) @(posedge clk);
        #2;
        chk("midfill_char0", 512'(out_block[15:0]), 512'({8'h00, pw[7:0]}));
        rst = 1'b1;
        #1;
        chk("midfill_rst_block", out_block, '0);
        chk("midfill_rst_valid", 512'(out_valid), 512'(0));
        chk("midfill_rst_in_ready", 512'(in_ready), 512'(1));
        chk("midfill_rst_err", 512'(err), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        watch_quiet(30, errs, valids);
        chk("midfill_no_valid", 512'(valids), 512'(0));

`ifdef PWENC_CHARCHECK_EN
        pulse_trigger(160'h4544194241, 5'd5);
        watch_quiet(15, errs, valids);
        chk("badchar_err", 512'(errs), 512'(1));
        chk("badchar_no_valid", 512'(valids), 512'(0));
        chk("badchar_block", out_block, '0);
`endif

        chk("sb_drained", 512'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
